// File: rtl/usb_ft232h_bridge.sv
// usb_ft232h_bridge
//
// Bridge between an FT232H running in 245 synchronous FIFO mode and the
// scanner core. All logic runs on the FT232H CLKOUT (60 MHz) rising edge.
// Two 256-byte FIFOs sit behind the shared bidirectional ADBUS:
//   RX FIFO : host -> FPGA, filled from the bus, popped by the core
//   TX FIFO : FPGA -> host, pushed by the core, drained onto the bus
// A small FSM decides which direction owns the bus. It always passes
// through a hi-Z cycle (RX_OE or TURN) so that the FPGA and the FT232H
// never drive ADBUS at the same time.
//
// Ports
//   usb_clk_i      FT232H CLKOUT, single clock
//   rst_i          asynchronous active-high reset
//   usb_data_io    FT232H ADBUS[7:0], bidirectional
//   usb_rxf_n_i    RXF#, low when the FT232H holds a byte for us
//   usb_txe_n_i    TXE#, low when the FT232H can accept a byte
//   usb_rd_n_o     RD#  (registered)
//   usb_wr_n_o     WR#  (registered)
//   usb_oe_n_o     OE#  (registered)
//   rxf_rdreq_i    pop RX FIFO head
//   rxf_rddata_o   RX FIFO head, show-ahead
//   rxf_rdusedw_o  RX FIFO occupancy, 0..DEPTH
//   txe_wrreq_i    push txe_wrdata_i into TX FIFO
//   txe_wrdata_i   byte to send to the host
//   txe_wrusedw_o  TX FIFO occupancy, 0..DEPTH
//   txe_wrfull_o   TX FIFO full

module usb_ft232h_bridge #(
    parameter int AW     = 8,
    parameter int RX_GAP = 2
) (
    input  logic          usb_clk_i,
    input  logic          rst_i,
    inout  wire  [7:0]    usb_data_io,
    input  logic          usb_rxf_n_i,
    input  logic          usb_txe_n_i,
    output logic          usb_rd_n_o,
    output logic          usb_wr_n_o,
    output logic          usb_oe_n_o,
    input  logic          rxf_rdreq_i,
    output logic [7:0]    rxf_rddata_o,
    output logic [AW:0]   rxf_rdusedw_o,
    input  logic          txe_wrreq_i,
    input  logic [7:0]    txe_wrdata_i,
    output logic [AW:0]   txe_wrusedw_o,
    output logic          txe_wrfull_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] RX_LIMIT = (AW+1)'(DEPTH - RX_GAP);

    typedef enum logic [2:0] {
        IDLE,
        RX_OE,
        RX_READ,
        TX_WRITE,
        TURN
    } state_t;

    state_t state_q, state_d;
    logic   rd_n_q, rd_n_d;
    logic   wr_n_q, wr_n_d;
    logic   oe_n_q, oe_n_d;

    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [AW:0]   rx_used_q, rx_used_d;
    logic [AW:0]   tx_used_q, tx_used_d;
    logic [AW:0]   tx_used_after_pop;

    logic       rx_push, rx_pop;
    logic       tx_push, tx_pop;
    logic       tx_drive;
    logic [7:0] tx_head;

    // FIFO handshakes. Overflowing pushes and underflowing pops are dropped
    // here so the occupancy counters can never wrap.
    always_comb begin
        rx_push = ~rd_n_q & ~usb_rxf_n_i & (rx_used_q != DEPTH_W);
        rx_pop  = rxf_rdreq_i & (rx_used_q != '0);
        tx_push = txe_wrreq_i & (tx_used_q != DEPTH_W);
        tx_pop  = (state_q == TX_WRITE) & ~wr_n_q & ~usb_txe_n_i
                  & (tx_used_q != '0);

        rx_used_d         = rx_used_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        tx_used_d         = tx_used_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        tx_used_after_pop = tx_used_q - (AW+1)'(tx_pop);
    end

    // FIFO storage has no reset; only the pointers and counters define
    // which entries are valid.
    always_ff @(posedge usb_clk_i) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= usb_data_io;
        end
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= txe_wrdata_i;
        end
    end

    // FIFO pointers and occupancy counters.
    always_ff @(posedge usb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_used_q   <= '0;
            tx_used_q   <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
            rx_used_q <= rx_used_d;
            tx_used_q <= tx_used_d;
        end
    end

    // FSM state and the registered FT232H strobes. Reset forces every
    // strobe high immediately, abandoning any byte in flight.
    always_ff @(posedge usb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    // Next-state and next-strobe logic.
    // RX wins over TX in IDLE. The RX exit test looks at the occupancy
    // after this edge's push, so reading stops exactly at RX_LIMIT and the
    // FT232H is never asked for a byte we could not store.
    // WR# is pulled low on the IDLE->TX_WRITE edge so the first byte goes
    // out one clock after TXE# is seen low; a byte only leaves the FIFO
    // when TXE# is low under a low WR#, so a TXE# rise costs no data.
    always_comb begin
        state_d = state_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        oe_n_d  = oe_n_q;

        case (state_q)
            IDLE: begin
                rd_n_d = 1'b1;
                wr_n_d = 1'b1;
                oe_n_d = 1'b1;
                if (~usb_rxf_n_i && (rx_used_q < RX_LIMIT)) begin
                    state_d = RX_OE;
                    oe_n_d  = 1'b0;
                end else if (~usb_txe_n_i && (tx_used_q != '0)) begin
                    state_d = TX_WRITE;
                    wr_n_d  = 1'b0;
                end
            end

            RX_OE: begin
                oe_n_d  = 1'b0;
                rd_n_d  = 1'b0;
                state_d = RX_READ;
            end

            RX_READ: begin
                if (usb_rxf_n_i || (rx_used_d >= RX_LIMIT)) begin
                    rd_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_n_d = 1'b0;
                    oe_n_d = 1'b0;
                end
            end

            TX_WRITE: begin
                if ((tx_used_after_pop == '0) || usb_txe_n_i || ~usb_rxf_n_i) begin
                    wr_n_d  = 1'b1;
                    state_d = TURN;
                end else begin
                    wr_n_d = 1'b0;
                end
            end

            TURN: begin
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // The FPGA only drives ADBUS while writing with OE# high; every other
    // state leaves the bus floating for the FT232H.
    always_comb begin
        tx_drive = (state_q == TX_WRITE) & oe_n_q;
        tx_head  = tx_mem_q[tx_rd_ptr_q];
    end

    assign usb_data_io = tx_drive ? tx_head : 8'bz;

    assign usb_rd_n_o    = rd_n_q;
    assign usb_wr_n_o    = wr_n_q;
    assign usb_oe_n_o    = oe_n_q;
    assign rxf_rddata_o  = rx_mem_q[rx_rd_ptr_q];
    assign rxf_rdusedw_o = rx_used_q;
    assign txe_wrusedw_o = tx_used_q;
    assign txe_wrfull_o  = (tx_used_q == DEPTH_W);

endmodule

// File: tb/tb_usb_ft232h_bridge.sv
// Testbench for usb_ft232h_bridge.
// A behavioural FT232H sits on the other side of ADBUS: it sources RX bytes
// from a queue while OE# is low and captures TX bytes whenever WR# and TXE#
// are both low. Expected bytes are queued when stimulus is created and
// compared as the core pops RX data or as TX bytes reach the model.

module tb_usb_ft232h_bridge;

   logic       usbClk = 1'b0;
   logic       rst = 1'b1;
   wire  [7:0] usbData;
   logic       rxfN = 1'b1;
   logic       txeN = 1'b1;
   wire        rdN, wrN, oeN;
   logic       rxfRdreq = 1'b0;
   wire  [7:0] rxfRddata;
   wire  [8:0] rxfRdusedw;
   logic       txeWrreq = 1'b0;
   logic [7:0] txeWrdata = 8'h00;
   wire  [8:0] txeWrusedw;
   wire        txeWrfull;

   logic [7:0] rxByte = 8'h00;
   logic [7:0] rxSrc[$];
   logic [7:0] rxExp[$];
   logic [7:0] txExp[$];
   logic [7:0] txGot[$];

   int checks = 0;
   int errors = 0;

   usb_ft232h_bridge dut (
      .usb_clk_i    (usbClk),
      .rst_i        (rst),
      .usb_data_io  (usbData),
      .usb_rxf_n_i  (rxfN),
      .usb_txe_n_i  (txeN),
      .usb_rd_n_o   (rdN),
      .usb_wr_n_o   (wrN),
      .usb_oe_n_o   (oeN),
      .rxf_rdreq_i  (rxfRdreq),
      .rxf_rddata_o (rxfRddata),
      .rxf_rdusedw_o(rxfRdusedw),
      .txe_wrreq_i  (txeWrreq),
      .txe_wrdata_i (txeWrdata),
      .txe_wrusedw_o(txeWrusedw),
      .txe_wrfull_o (txeWrfull)
   );

   always #8 usbClk = ~usbClk;

   // The FT232H side only drives the bus while OE# is low.
   assign usbData = (oeN == 1'b0) ? rxByte : 8'bz;

   // FT232H model: sample strobes at the edge, update RXF#/data shortly after.
   always @(posedge usbClk) begin
      logic take;
      take = (rdN == 1'b0) && (rxfN == 1'b0);
      if (wrN == 1'b0 && txeN == 1'b0) txGot.push_back(usbData);
      #1;
      if (take && rxSrc.size() > 0) void'(rxSrc.pop_front());
      rxfN   = (rxSrc.size() == 0);
      rxByte = (rxSrc.size() > 0) ? rxSrc[0] : 8'h00;
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge usbClk);
      checks++; if (rdN !== 1'b1) begin errors++; $display("[TB] FAIL reset_rd_n got %b want 1", rdN); end
      checks++; if (wrN !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_n got %b want 1", wrN); end
      checks++; if (oeN !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe_n got %b want 1", oeN); end
      checks++; if (rxfRdusedw !== 9'd0) begin errors++; $display("[TB] FAIL reset_rx_used got %0d want 0", rxfRdusedw); end
      checks++; if (txeWrusedw !== 9'd0) begin errors++; $display("[TB] FAIL reset_tx_used got %0d want 0", txeWrusedw); end
      checks++; if (txeWrfull !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", txeWrfull); end
      rst = 1'b0;
      repeat (4) @(negedge usbClk);
      checks++; if ({rdN, wrN, oeN} !== 3'b111) begin errors++; $display("[TB] FAIL idle_strobes got %b want 111", {rdN, wrN, oeN}); end
      checks++; if (rxfRdusedw !== 9'd0 || txeWrusedw !== 9'd0) begin errors++; $display("[TB] FAIL idle_used got rx %0d tx %0d want 0 0", rxfRdusedw, txeWrusedw); end
   endtask

   task automatic test_tx_fill();
      int wrLow = 0;
      txeN = 1'b1;
      for (int i = 0; i < 256; i++) begin
         txeWrreq  = 1'b1;
         txeWrdata = 8'(i);
         txExp.push_back(8'(i));
         @(negedge usbClk);
         if (wrN !== 1'b1) wrLow++;
      end
      txeWrreq = 1'b0;
      checks++; if (txeWrusedw !== 9'd256) begin errors++; $display("[TB] FAIL fill_used got %0d want 256", txeWrusedw); end
      checks++; if (txeWrfull !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %b want 1", txeWrfull); end
      txeWrreq  = 1'b1;
      txeWrdata = 8'hEE;
      @(negedge usbClk);
      txeWrreq = 1'b0;
      if (wrN !== 1'b1) wrLow++;
      @(negedge usbClk);
      checks++; if (txeWrusedw !== 9'd256) begin errors++; $display("[TB] FAIL overflow_used got %0d want 256", txeWrusedw); end
      checks++; if (wrLow !== 0) begin errors++; $display("[TB] FAIL fill_wr_n got %0d low cycles want 0", wrLow); end
   endtask

   task automatic test_tx_drain();
      int cycles = 1;
      int n;
      txeN = 1'b0;
      @(negedge usbClk);
      checks++; if (wrN !== 1'b0) begin errors++; $display("[TB] FAIL drain_wr_low got %b want 0", wrN); end
      checks++; if (usbData !== 8'h00) begin errors++; $display("[TB] FAIL drain_first_bus got %h want 00", usbData); end
      while (txeWrusedw != 9'd0 && cycles < 600) begin
         @(negedge usbClk);
         cycles++;
      end
      checks++; if (cycles != 257) begin errors++; $display("[TB] FAIL drain_cycles got %0d want 257", cycles); end
      repeat (3) @(negedge usbClk);
      checks++; if (txeWrfull !== 1'b0) begin errors++; $display("[TB] FAIL drain_full got %b want 0", txeWrfull); end
      checks++; if (wrN !== 1'b1) begin errors++; $display("[TB] FAIL drain_wr_idle got %b want 1", wrN); end
      checks++; if (txGot.size() != 256) begin errors++; $display("[TB] FAIL drain_count got %0d want 256", txGot.size()); end
      n = 0;
      while (txGot.size() > 0 && txExp.size() > 0) begin
         logic [7:0] got, exp;
         got = txGot.pop_front();
         exp = txExp.pop_front();
         checks++; if (got !== exp) begin errors++; $display("[TB] FAIL drain_byte%0d got %h want %h", n, got, exp); end
         n++;
      end
      txGot.delete();
      txExp.delete();
      txeN = 1'b1;
   endtask

   task automatic test_tx_stall();
      int cycles = 0;
      int n;
      for (int i = 0; i < 40; i++) begin
         txeWrreq  = 1'b1;
         txeWrdata = 8'(i * 3 + 7);
         txExp.push_back(8'(i * 3 + 7));
         @(negedge usbClk);
      end
      txeWrreq = 1'b0;
      txeN = 1'b0;
      repeat (10) @(negedge usbClk);
      txeN = 1'b1;
      repeat (3) @(negedge usbClk);
      checks++; if (txGot.size() == 0 || txGot.size() >= 40) begin errors++; $display("[TB] FAIL stall_partial got %0d bytes want 1..39", txGot.size()); end
      txeN = 1'b0;
      while (txeWrusedw != 9'd0 && cycles < 200) begin
         @(negedge usbClk);
         cycles++;
      end
      repeat (3) @(negedge usbClk);
      checks++; if (txGot.size() != 40) begin errors++; $display("[TB] FAIL stall_count got %0d want 40", txGot.size()); end
      n = 0;
      while (txGot.size() > 0 && txExp.size() > 0) begin
         logic [7:0] got, exp;
         got = txGot.pop_front();
         exp = txExp.pop_front();
         checks++; if (got !== exp) begin errors++; $display("[TB] FAIL stall_byte%0d got %h want %h", n, got, exp); end
         n++;
      end
      txGot.delete();
      txExp.delete();
      txeN = 1'b1;
   endtask

   task automatic test_rx_burst();
      int cycles = 0;
      for (int i = 0; i < 10; i++) begin
         rxSrc.push_back(8'hA0 + 8'(i));
         rxExp.push_back(8'hA0 + 8'(i));
      end
      while (oeN !== 1'b0 && cycles < 20) begin
         @(negedge usbClk);
         cycles++;
      end
      checks++; if (oeN !== 1'b0) begin errors++; $display("[TB] FAIL burst_oe got %b want 0 within 20 cycles", oeN); end
      checks++; if (rdN !== 1'b1) begin errors++; $display("[TB] FAIL burst_oe_before_rd got rd %b want 1", rdN); end
      @(negedge usbClk);
      checks++; if (rdN !== 1'b0 || oeN !== 1'b0) begin errors++; $display("[TB] FAIL burst_rd_low got rd %b oe %b want 0 0", rdN, oeN); end
      cycles = 0;
      while (!(rdN === 1'b1 && rxfN === 1'b1) && cycles < 40) begin
         @(negedge usbClk);
         cycles++;
      end
      checks++; if (rxfRdusedw !== 9'd10) begin errors++; $display("[TB] FAIL burst_used got %0d want 10", rxfRdusedw); end
      checks++; if (oeN !== 1'b1) begin errors++; $display("[TB] FAIL burst_oe_end got %b want 1", oeN); end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] exp;
         exp = rxExp.pop_front();
         checks++; if (rxfRddata !== exp) begin errors++; $display("[TB] FAIL burst_pop%0d got %h want %h", i, rxfRddata, exp); end
         rxfRdreq = 1'b1;
         @(negedge usbClk);
      end
      rxfRdreq = 1'b0;
      @(negedge usbClk);
      checks++; if (rxfRdusedw !== 9'd0) begin errors++; $display("[TB] FAIL burst_empty got %0d want 0", rxfRdusedw); end
   endtask

   task automatic test_rx_backpressure();
      int cycles = 0;
      int popped = 0;
      for (int i = 0; i < 300; i++) begin
         rxSrc.push_back(8'(i * 7 + 1));
         rxExp.push_back(8'(i * 7 + 1));
      end
      while (!(rxfRdusedw === 9'd254 && rdN === 1'b1 && oeN === 1'b1) && cycles < 600) begin
         @(negedge usbClk);
         cycles++;
      end
      repeat (5) @(negedge usbClk);
      checks++; if (rxfRdusedw !== 9'd254) begin errors++; $display("[TB] FAIL bp_stop_used got %0d want 254", rxfRdusedw); end
      checks++; if (rdN !== 1'b1 || oeN !== 1'b1) begin errors++; $display("[TB] FAIL bp_stop_strobes got rd %b oe %b want 1 1", rdN, oeN); end
      checks++; if (rxSrc.size() != 46) begin errors++; $display("[TB] FAIL bp_consumed got %0d left want 46", rxSrc.size()); end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] exp;
         exp = rxExp.pop_front();
         checks++; if (rxfRddata !== exp) begin errors++; $display("[TB] FAIL bp_pop%0d got %h want %h", i, rxfRddata, exp); end
         rxfRdreq = 1'b1;
         popped++;
         @(negedge usbClk);
      end
      rxfRdreq = 1'b0;
      repeat (8) @(negedge usbClk);
      checks++; if (rxfRdusedw !== 9'd254 || rxSrc.size() != 36) begin errors++; $display("[TB] FAIL bp_resume got used %0d left %0d want 254 36", rxfRdusedw, rxSrc.size()); end
      cycles = 0;
      while (popped < 300 && cycles < 3000) begin
         if (rxfRdusedw != 9'd0) begin
            logic [7:0] exp;
            exp = rxExp.pop_front();
            checks++; if (rxfRddata !== exp) begin errors++; $display("[TB] FAIL bp_drain%0d got %h want %h", popped, rxfRddata, exp); end
            rxfRdreq = 1'b1;
            popped++;
         end else begin
            rxfRdreq = 1'b0;
         end
         @(negedge usbClk);
         cycles++;
      end
      rxfRdreq = 1'b0;
      repeat (3) @(negedge usbClk);
      checks++; if (popped != 300) begin errors++; $display("[TB] FAIL bp_total got %0d want 300", popped); end
      checks++; if (rxfRdusedw !== 9'd0 || rxSrc.size() != 0) begin errors++; $display("[TB] FAIL bp_final got used %0d left %0d want 0 0", rxfRdusedw, rxSrc.size()); end
   endtask

   initial begin
      $display("[TB] usb_ft232h_bridge bench start");
      test_reset();
      test_tx_fill();
      test_tx_drain();
      test_tx_stall();
      test_rx_burst();
      test_rx_backpressure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
